uart_rx_param: RTL and testbench

Parametrised UART receiver; next generation of the fixed 8N1 receiver.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Adds an input synchroniser, start-bit glitch rejection, error flags and a valid/ready output handshake.
- Sits between the external RX pin and the byte-stream consumer (FIFO or command parser).

---
 rtl/uart_rx_param.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling,
// optional parity, 1-2 stop bits, error pulses and a valid/ready output.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLK_FREQ  = 10000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CPB = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic                 sync1_q, sync2_q, rx_s;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;

  assign rx_s = sync2_q;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame sequencer: bit timing, sampling and per-frame error detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            perr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 1) ? ~(^shreg_q ^ rx_s) : (^shreg_q ^ rx_s);
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end else if (idx_q == STOP_LAST) begin
            // Leave at mid-stop so a following start bit is never missed.
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Output handshake: load a finished frame if the slot is free or being
  // accepted this cycle, otherwise drop it and flag overrun.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ovr_d      = 1'b0;
    if (valid_q && out_ready) begin
      valid_d    = 1'b0;
      perr_out_d = 1'b0;
    end
    if (done_q) begin
      if (!valid_q || out_ready) begin
        data_d     = shreg_q;
        perr_out_d = perr_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 7E1, 9O2) at 10 clks/bit.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rxa = 1'b1, rxb = 1'b1, rxc = 1'b1;
  logic ready_a = 1'b0, ready_b = 1'b1, ready_c = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [8:0] data_c;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, busy_b;
  logic valid_c, perr_c, ferr_c, ovr_c, busy_c;

  uart_rx_param #(.CLK_FREQ(10000000), .BAUD_RATE(1000000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rxa), .out_data(data_a), .out_valid(valid_a),
    .out_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .busy(busy_a));

  uart_rx_param #(.CLK_FREQ(10000000), .BAUD_RATE(1000000), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rxb), .out_data(data_b), .out_valid(valid_b),
    .out_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .busy(busy_b));

  uart_rx_param #(.CLK_FREQ(10000000), .BAUD_RATE(1000000), .DATA_BITS(9),
                  .PARITY(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .rx(rxc), .out_data(data_c), .out_valid(valid_c),
    .out_ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c),
    .overrun(ovr_c), .busy(busy_c));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Monitors: record rising out_valid and count error pulses.
  int rises_a = 0, ferrs_a = 0, ovrs_a = 0;
  logic prev_a = 1'b0, last_perr_a = 1'b0;
  logic [7:0] last_data_a = '0;
  int unsigned rise_cyc_a = 0;
  always @(negedge clk) begin
    prev_a <= valid_a;
    if (valid_a && !prev_a) begin
      rises_a     <= rises_a + 1;
      last_data_a <= data_a;
      last_perr_a <= perr_a;
      rise_cyc_a  <= cyc;
    end
    if (ferr_a) ferrs_a <= ferrs_a + 1;
    if (ovr_a)  ovrs_a  <= ovrs_a + 1;
  end

  int rises_b = 0, ferrs_b = 0, ovrs_b = 0;
  logic prev_b = 1'b0, last_perr_b = 1'b0;
  logic [6:0] last_data_b = '0;
  always @(negedge clk) begin
    prev_b <= valid_b;
    if (valid_b && !prev_b) begin
      rises_b     <= rises_b + 1;
      last_data_b <= data_b;
      last_perr_b <= perr_b;
    end
    if (ferr_b) ferrs_b <= ferrs_b + 1;
    if (ovr_b)  ovrs_b  <= ovrs_b + 1;
  end

  typedef struct { logic [8:0] d; logic p; } rec_t;
  rec_t exp_q[$];
  rec_t got_q[$];
  int ferrs_c = 0, ovrs_c = 0;
  always @(negedge clk) begin
    if (valid_c && ready_c) got_q.push_back(rec_t'{data_c, perr_c});
    if (ferr_c) ferrs_c <= ferrs_c + 1;
    if (ovr_c)  ovrs_c  <= ovrs_c + 1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_c = ($urandom_range(3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int w, input logic b);
    case (w)
      0: rxa = b;
      1: rxb = b;
      default: rxc = b;
    endcase
  endtask

  task automatic send_frame(input int w, input logic [8:0] d, input int nb,
                            input int par_en, input logic pbit,
                            input int nstop, input logic stop_val);
    set_rx(w, 1'b0);
    tick(CPB);
    for (int i = 0; i < nb; i++) begin
      set_rx(w, d[i]);
      tick(CPB);
    end
    if (par_en != 0) begin
      set_rx(w, pbit);
      tick(CPB);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(w, stop_val);
      tick(CPB);
    end
    set_rx(w, 1'b1);
  endtask

  typedef struct {
    logic [6:0] data;
    logic       pbit;
    logic       stop;
    logic [6:0] exp_data;
    logic       exp_perr;
    int         exp_frames;
    int         exp_ferr;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int unsigned t0;
    int r0, f0;

    // 7E1 vectors: parity error when total ones (data + parity bit) is odd.
    tbl[0] = '{7'h35, 1'b0, 1'b1, 7'h35, 1'b0, 1, 0};
    tbl[1] = '{7'h35, 1'b1, 1'b1, 7'h35, 1'b1, 1, 0};
    tbl[2] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b0, 1, 0};
    tbl[3] = '{7'h7F, 1'b0, 1'b1, 7'h7F, 1'b1, 1, 0};
    tbl[4] = '{7'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1, 0};
    tbl[5] = '{7'h40, 1'b0, 1'b1, 7'h40, 1'b1, 1, 0};
    tbl[6] = '{7'h2A, 1'b1, 1'b0, 7'h00, 1'b0, 0, 1};
    tbl[7] = '{7'h55, 1'b0, 1'b1, 7'h55, 1'b0, 1, 0};

    rst_n = 1'b0;
    tick(3);
    chk("reset_a", {data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a}, 0);
    chk("reset_b", {data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b}, 0);
    chk("reset_c", {data_c, valid_c, perr_c, ferr_c, ovr_c, busy_c}, 0);
    rst_n = 1'b1;
    tick(3);

    // 8N1 0xA5: latency and handshake.
    ready_a = 1'b0;
    t0 = cyc;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    tick(2);
    chk("a5_frames", rises_a, 1);
    chk("a5_data", last_data_a, 8'hA5);
    chk("a5_perr", last_perr_a, 0);
    chk("a5_latency", rise_cyc_a - (t0 + 1), 2 + CPB/2 + 9*CPB + 1);
    chk("a5_held", valid_a, 1);
    ready_a = 1'b1;
    tick(1);
    chk("a5_cleared", valid_a, 0);
    chk("a5_data_kept", data_a, 8'hA5);

    // Short glitch on idle line.
    rxa = 1'b0;
    tick(3);
    chk("glitch_busy", busy_a, 1);
    rxa = 1'b1;
    tick(20);
    chk("glitch_idle", busy_a, 0);
    chk("glitch_no_frame", rises_a, 1);
    chk("glitch_no_flags", {ferrs_a[7:0], ovrs_a[7:0]}, 0);

    // Stop bit low, break, then recovery.
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0);
    rxa = 1'b0;
    tick(50);
    rxa = 1'b1;
    tick(5);
    chk("ferr_pulses", ferrs_a, 1);
    chk("ferr_no_frame", rises_a, 1);
    chk("ferr_idle", busy_a, 0);
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    tick(3);
    chk("recover_frames", rises_a, 2);
    chk("recover_data", last_data_a, 8'h11);

    // Back-to-back with consumer stalled.
    ready_a = 1'b0;
    send_frame(0, 9'h001, 8, 0, 1'b0, 1, 1'b1);
    send_frame(0, 9'h002, 8, 0, 1'b0, 1, 1'b1);
    tick(3);
    chk("b2b_frames", rises_a, 3);
    chk("b2b_overruns", ovrs_a, 1);
    chk("b2b_valid", valid_a, 1);
    chk("b2b_data", data_a, 8'h01);
    ready_a = 1'b1;
    tick(1);
    chk("b2b_cleared", valid_a, 0);
    chk("b2b_data_kept", data_a, 8'h01);

    // Reset during DATA of 0xFF.
    rxa = 1'b0;
    tick(CPB);
    rxa = 1'b1;
    tick(25);
    chk("rst_mid_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
    tick(3);
    chk("rst_mid_frames", rises_a, 4);
    chk("rst_mid_data", last_data_a, 8'h5A);

    // Table-driven 7E1 vectors.
    for (int i = 0; i < 8; i++) begin
      r0 = rises_b;
      f0 = ferrs_b;
      send_frame(1, {2'b00, tbl[i].data}, 7, 1, tbl[i].pbit, 1, tbl[i].stop);
      tick(5);
      chk($sformatf("tbl%0d_frames", i), rises_b - r0, tbl[i].exp_frames);
      chk($sformatf("tbl%0d_ferr", i), ferrs_b - f0, tbl[i].exp_ferr);
      if (tbl[i].exp_frames != 0) begin
        chk($sformatf("tbl%0d_data", i), last_data_b, tbl[i].exp_data);
        chk($sformatf("tbl%0d_perr", i), last_perr_b, tbl[i].exp_perr);
      end
    end
    chk("tbl_overruns", ovrs_b, 0);

    // Randomised 9O2 frames against a parity-count model.
    for (int n = 0; n < 30; n++) begin
      logic [8:0] d;
      logic pb;
      int ones;
      d    = 9'($urandom);
      pb   = 1'($urandom_range(1));
      ones = $countones(d) + int'(pb);
      exp_q.push_back(rec_t'{d, (ones % 2) == 0});
      send_frame(2, d, 9, 1, pb, 2, 1'b1);
      tick($urandom_range(15));
    end
    tick(20);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("rand%0d_data", i), got_q[i].d, exp_q[i].d);
        chk($sformatf("rand%0d_perr", i), got_q[i].p, exp_q[i].p);
      end
    end
    chk("rand_flags", {ferrs_c[7:0], ovrs_c[7:0]}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
